// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: CPU requester, host requester and
// BRAM port A signals. The arbiter connects through the slave modport;
// the surrounding environment drives through the master modport.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // CPU requester
  logic              cpu_req_i;
  logic [BE_W-1:0]   cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_gnt_o;
  logic              cpu_rvalid_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_stall_o;

  // Host / debug requester
  logic              host_req_i;
  logic [BE_W-1:0]   host_we_i;
  logic [31:0]       host_addr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic              host_lock_i;
  logic              host_gnt_o;
  logic              host_rvalid_o;
  logic [DATA_W-1:0] host_rdata_o;

  // BRAM port A
  logic              mem_en_o;
  logic [BE_W-1:0]   mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_stall_o,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_stall_o,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares data-memory BRAM port A between the CPU
// load/store path and a host/debug master. Registered round-robin
// arbitration, one access per cycle, read data returned two cycles after
// the winning request with a per-requester valid pulse.
// Optional host lock with starvation timeout: define DMEM_ARB_HOST_LOCK_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_HOST = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              host_gnt_q, host_gnt_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              host_rd_q, host_rd_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              mem_en_q, mem_en_d;
  logic [BE_W-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic cpu_win;
  logic host_win;
  logic host_prio;

  // Address bits outside the word-address window are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.cpu_addr_i[31:ADDR_W+2], bus.cpu_addr_i[1:0],
                         bus.host_addr_i[31:ADDR_W+2], bus.host_addr_i[1:0]};

`ifdef DMEM_ARB_HOST_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // Host keeps priority while locked, until the CPU has been starved
  // for LOCK_TIMEOUT cycles; then normal round-robin hands it one slot.
  assign host_prio = bus.host_lock_i && (last_grant_q == GRANT_HOST) &&
                     (lock_cnt_q < CNT_W'(LOCK_TIMEOUT));

  // Starvation counter: counts blocked CPU cycles, saturating at the timeout.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!bus.host_lock_i || cpu_win) begin
      lock_cnt_d = '0;
    end else if (bus.cpu_req_i && (lock_cnt_q < CNT_W'(LOCK_TIMEOUT))) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = bus.host_lock_i & (LOCK_TIMEOUT > 0);
  assign host_prio   = 1'b0;
`endif

  // Arbitration decision over the current requests.
  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (bus.cpu_req_i && bus.host_req_i) begin
      if (host_prio) begin
        host_win = 1'b1;
      end else if (last_grant_q == GRANT_HOST) begin
        cpu_win = 1'b1;
      end else begin
        host_win = 1'b1;
      end
    end else if (bus.cpu_req_i) begin
      cpu_win = 1'b1;
    end else if (bus.host_req_i) begin
      host_win = 1'b1;
    end
  end

  // Next-state for grant, BRAM command and read-valid pipeline.
  always_comb begin
    last_grant_d  = last_grant_q;
    mem_en_d      = cpu_win | host_win;
    mem_we_d      = '0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_gnt_d     = cpu_win;
    host_gnt_d    = host_win;
    cpu_rd_d      = cpu_win && (bus.cpu_we_i == '0);
    host_rd_d     = host_win && (bus.host_we_i == '0);
    cpu_rvalid_d  = cpu_rd_q;
    host_rvalid_d = host_rd_q;
    if (cpu_win) begin
      last_grant_d = GRANT_CPU;
      mem_we_d     = bus.cpu_we_i;
      mem_addr_d   = bus.cpu_addr_i[ADDR_W+1:2];
      mem_wdata_d  = bus.cpu_wdata_i;
    end else if (host_win) begin
      last_grant_d = GRANT_HOST;
      mem_we_d     = bus.host_we_i;
      mem_addr_d   = bus.host_addr_i[ADDR_W+1:2];
      mem_wdata_d  = bus.host_wdata_i;
    end
  end

  // State registers; reset drops any in-flight read valids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q  <= GRANT_HOST;
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rd_q      <= 1'b0;
      host_rd_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      cpu_gnt_q     <= cpu_gnt_d;
      host_gnt_q    <= host_gnt_d;
      cpu_rd_q      <= cpu_rd_d;
      host_rd_q     <= host_rd_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.cpu_gnt_o     = cpu_gnt_q;
  assign bus.host_gnt_o    = host_gnt_q;
  assign bus.cpu_rvalid_o  = cpu_rvalid_q;
  assign bus.host_rvalid_o = host_rvalid_q;
  assign bus.cpu_rdata_o   = bus.mem_rdata_i;
  assign bus.host_rdata_o  = bus.mem_rdata_i;
  assign bus.mem_en_o      = mem_en_q;
  assign bus.mem_we_o      = mem_we_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wdata_o   = mem_wdata_q;
  assign bus.cpu_stall_o   = reset & bus.cpu_req_i & ~cpu_win;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a small read-first BRAM
// stand-in on port A.
module tb_dmem_port_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_port_arbiter_if #(.ADDR_W(15), .DATA_W(32)) bus ();

  dmem_port_arbiter #(
    .ADDR_W      (15),
    .DATA_W      (32),
    .LOCK_TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-in: synchronous read, byte-enabled write, preloaded once.
  logic [31:0] bram [0:255];
  logic        bram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bram_loaded) begin
      for (int i = 0; i < 256; i++) bram[i] <= 32'h0;
      bram[0] <= 32'h0000_00A0;
      bram[1] <= 32'h0000_00A1;
      bram[2] <= 32'h0000_00A2;
      bram[4] <= 32'hDEAD_BEEF;
      bram[8] <= 32'h1122_3344;
      bram_loaded <= 1'b1;
    end else if (bus.mem_en_o) begin
      bus.mem_rdata_i <= bram[bus.mem_addr_o[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b])
          bram[bus.mem_addr_o[7:0]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.cpu_req_i  = 1'b0;
    bus.host_req_i = 1'b0;
    bus.host_lock_i = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_gnt"},    32'(bus.cpu_gnt_o),     32'h0);
    chk({tag, "_host_gnt"},   32'(bus.host_gnt_o),    32'h0);
    chk({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid_o),  32'h0);
    chk({tag, "_host_rvalid"},32'(bus.host_rvalid_o), 32'h0);
    chk({tag, "_mem_en"},     32'(bus.mem_en_o),      32'h0);
    chk({tag, "_mem_we"},     32'(bus.mem_we_o),      32'h0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr_o),    32'h0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata_o,        32'h0);
    chk({tag, "_stall"},      32'(bus.cpu_stall_o),   32'h0);
  endtask

  logic [9:0] exp_cpu_win;

  initial begin
    checks = 0;
    errors = 0;
    reset            = 1'b0;
    bus.cpu_req_i    = 1'b1;
    bus.cpu_we_i     = 4'h0;
    bus.cpu_addr_i   = 32'h0;
    bus.cpu_wdata_i  = 32'h0;
    bus.host_req_i   = 1'b0;
    bus.host_we_i    = 4'h0;
    bus.host_addr_i  = 32'h0;
    bus.host_wdata_i = 32'h0;
    bus.host_lock_i  = 1'b0;

    // Reset state (CPU request asserted: stall must still be 0)
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    bus.cpu_req_i = 1'b0;
    reset = 1'b1;

    // CPU-only read of 0x10 -> word 4
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 4'h0;
    bus.cpu_addr_i = 32'h0000_0010;
    #1;
    chk("rd_stall", 32'(bus.cpu_stall_o), 32'h0);
    step();
    chk("rd_cpu_gnt",  32'(bus.cpu_gnt_o),  32'h1);
    chk("rd_host_gnt", 32'(bus.host_gnt_o), 32'h0);
    chk("rd_mem_en",   32'(bus.mem_en_o),   32'h1);
    chk("rd_mem_we",   32'(bus.mem_we_o),   32'h0);
    chk("rd_mem_addr", 32'(bus.mem_addr_o), 32'h4);
    chk("rd_rvalid_early", 32'(bus.cpu_rvalid_o), 32'h0);
    bus.cpu_req_i = 1'b0;
    step();
    chk("rd_cpu_rvalid",  32'(bus.cpu_rvalid_o),  32'h1);
    chk("rd_cpu_rdata",   bus.cpu_rdata_o,        32'hDEAD_BEEF);
    chk("rd_host_rvalid", 32'(bus.host_rvalid_o), 32'h0);
    chk("rd_idle_en",     32'(bus.mem_en_o),      32'h0);
    chk("rd_idle_addr",   32'(bus.mem_addr_o),    32'h4);
    step();
    chk("rd_rvalid_done", 32'(bus.cpu_rvalid_o),  32'h0);

    // Both requesting continuously from the first cycle after reset
    do_reset();
    bus.cpu_req_i   = 1'b1;
    bus.cpu_addr_i  = 32'h0;
    bus.host_req_i  = 1'b1;
    bus.host_we_i   = 4'h0;
    bus.host_addr_i = 32'h4;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("alt_stall", 32'(bus.cpu_stall_o), 32'(k % 2));
      step();
      chk("alt_cpu_gnt",  32'(bus.cpu_gnt_o),  32'(k % 2 == 0));
      chk("alt_host_gnt", 32'(bus.host_gnt_o), 32'(k % 2 == 1));
    end
    bus.cpu_req_i  = 1'b0;
    bus.host_req_i = 1'b0;
    step();
    step();

    // Host partial write to 0x20, then CPU read-back
    bus.host_req_i   = 1'b1;
    bus.host_we_i    = 4'b0011;
    bus.host_addr_i  = 32'h0000_0020;
    bus.host_wdata_i = 32'h0000_ABCD;
    step();
    chk("wr_host_gnt",  32'(bus.host_gnt_o),  32'h1);
    chk("wr_mem_we",    32'(bus.mem_we_o),    32'h3);
    chk("wr_mem_addr",  32'(bus.mem_addr_o),  32'h8);
    chk("wr_mem_wdata", bus.mem_wdata_o,      32'h0000_ABCD);
    bus.host_req_i = 1'b0;
    bus.host_we_i  = 4'h0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 4'h0;
    bus.cpu_addr_i = 32'h0000_0020;
    step();
    chk("wr_cpu_gnt",     32'(bus.cpu_gnt_o),     32'h1);
    chk("wr_host_rvalid", 32'(bus.host_rvalid_o), 32'h0);
    bus.cpu_req_i = 1'b0;
    step();
    chk("wr_cpu_rvalid",  32'(bus.cpu_rvalid_o),  32'h1);
    chk("wr_cpu_rdata",   bus.cpu_rdata_o,        32'h1122_ABCD);
    chk("wr_host_rv2",    32'(bus.host_rvalid_o), 32'h0);
    step();

    // CPU back-to-back reads of 0, 4, 8
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0;
    step();
    chk("b2b_gnt0",  32'(bus.cpu_gnt_o),  32'h1);
    chk("b2b_en0",   32'(bus.mem_en_o),   32'h1);
    chk("b2b_addr0", 32'(bus.mem_addr_o), 32'h0);
    bus.cpu_addr_i = 32'h4;
    step();
    chk("b2b_gnt1",  32'(bus.cpu_gnt_o),    32'h1);
    chk("b2b_en1",   32'(bus.mem_en_o),     32'h1);
    chk("b2b_addr1", 32'(bus.mem_addr_o),   32'h1);
    chk("b2b_rv0",   32'(bus.cpu_rvalid_o), 32'h1);
    chk("b2b_rd0",   bus.cpu_rdata_o,       32'h0000_00A0);
    bus.cpu_addr_i = 32'h8;
    step();
    chk("b2b_gnt2",  32'(bus.cpu_gnt_o),    32'h1);
    chk("b2b_en2",   32'(bus.mem_en_o),     32'h1);
    chk("b2b_addr2", 32'(bus.mem_addr_o),   32'h2);
    chk("b2b_rv1",   32'(bus.cpu_rvalid_o), 32'h1);
    chk("b2b_rd1",   bus.cpu_rdata_o,       32'h0000_00A1);
    bus.cpu_req_i = 1'b0;
    step();
    chk("b2b_rv2",   32'(bus.cpu_rvalid_o), 32'h1);
    chk("b2b_rd2",   bus.cpu_rdata_o,       32'h0000_00A2);
    chk("b2b_en_off",32'(bus.mem_en_o),     32'h0);
    step();
    chk("b2b_rv_off",32'(bus.cpu_rvalid_o), 32'h0);

    // Reset asserted between gnt and rvalid
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0000_0010;
    step();
    chk("mr_gnt", 32'(bus.cpu_gnt_o), 32'h1);
    bus.cpu_req_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("mr");
    step();
    chk("mr_no_rvalid", 32'(bus.cpu_rvalid_o), 32'h0);
    reset = 1'b1;
    bus.cpu_req_i  = 1'b1;
    bus.host_req_i = 1'b1;
    #1;
    chk("mr_stall", 32'(bus.cpu_stall_o), 32'h0);
    step();
    chk("mr_cpu_first", 32'(bus.cpu_gnt_o),  32'h1);
    chk("mr_host_wait", 32'(bus.host_gnt_o), 32'h0);
    bus.cpu_req_i  = 1'b0;
    bus.host_req_i = 1'b0;
    step();
    step();

    // Host lock with both requesters active
`ifdef DMEM_ARB_HOST_LOCK_EN
    exp_cpu_win = 10'b10_0001_0000;
`else
    exp_cpu_win = 10'b01_0101_0101;
`endif
    do_reset();
    bus.host_lock_i = 1'b1;
    bus.cpu_req_i   = 1'b1;
    bus.host_req_i  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("lock_stall", 32'(bus.cpu_stall_o), 32'(!exp_cpu_win[k]));
      step();
      chk("lock_cpu_gnt",  32'(bus.cpu_gnt_o),  32'(exp_cpu_win[k]));
      chk("lock_host_gnt", 32'(bus.host_gnt_o), 32'(!exp_cpu_win[k]));
    end
    bus.cpu_req_i   = 1'b0;
    bus.host_req_i  = 1'b0;
    bus.host_lock_i = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
